seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit 7-segment display driver.
- Samples the display's digit-select and segment buses, waits for each digit's pattern to settle, and decodes it back to a hex nibble.
- Assembles a complete 16-bit frame with a one-cycle valid strobe.
- Used as an in-system display monitor and as a self-checking sink for counter/display benches.

---
 rtl/seg_scan_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed 4-digit 7-segment bus, waits for each digit to settle,
// decodes it back to hex, and publishes whole frames. Optional macro SEG_SCAN_CHANGE_ONLY_EN.

module seg_scan_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       clr,
    input  logic [3:0] nib_in,
    input  logic       dp_in,
    input  logic       err_in,
    output logic [3:0] nib,
    output logic       dp,
    output logic       err,
    output logic       seen
);
    // One shadow digit: clr drops the whole partial frame, including data.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            nib  <= '0;
            dp   <= 1'b0;
            err  <= 1'b0;
            seen <= 1'b0;
        end else if (wr) begin
            nib  <= nib_in;
            dp   <= dp_in;
            err  <= err_in;
            seen <= 1'b1;
        end
    end
endmodule

module seg_scan_decoder #(
    parameter int STABLE_CNT     = 4,
    parameter int TIMEOUT        = 65535,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        timeout
);
    localparam int          NUM_DIGITS  = 4;
    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_DWELL     = 2'd1;
    localparam logic [1:0]  S_HELD      = 2'd2;
    localparam logic [7:0]  STABLE_TGT  = 8'(STABLE_CNT);
    localparam logic [15:0] TIMEOUT_TGT = 16'(TIMEOUT);

    logic [3:0]  sel_q, sel_h, prev_sel;
    logic [7:0]  seg_q, seg_h, prev_seg;
    logic        one_hot, same;
    logic [1:0]  idx;
    logic [3:0]  glyph_nib;
    logic        glyph_err;
    logic [1:0]  state, state_nx;
    logic [7:0]  dwell, dwell_nx;
    logic        capture, complete, expire, clr, pulse_ok;
    logic [15:0] idle_cnt;

    logic [NUM_DIGITS-1:0]      wr, seen;
    logic [NUM_DIGITS-1:0][3:0] slot_nib, frame_nib;
    logic [NUM_DIGITS-1:0]      slot_dp, slot_err, frame_dp, frame_err;

    // Input register resets to the "nothing selected / all dark" level of the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= {4{SEL_ACTIVE_LOW}};
            seg_q <= {8{SEG_ACTIVE_LOW}};
        end else begin
            sel_q <= sel;
            seg_q <= seg;
        end
    end

    assign sel_h = sel_q ^ {4{SEL_ACTIVE_LOW}};
    assign seg_h = seg_q ^ {8{SEG_ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel <= '0;
            prev_seg <= '0;
        end else begin
            prev_sel <= sel_h;
            prev_seg <= seg_h;
        end
    end

    assign same = (sel_h == prev_sel) && (seg_h == prev_seg);

    always_comb begin
        one_hot = 1'b0;
        idx     = 2'd0;
        case (sel_h)
            4'b0001: begin one_hot = 1'b1; idx = 2'd0; end
            4'b0010: begin one_hot = 1'b1; idx = 2'd1; end
            4'b0100: begin one_hot = 1'b1; idx = 2'd2; end
            4'b1000: begin one_hot = 1'b1; idx = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        glyph_nib = 4'h0;
        glyph_err = 1'b0;
        case (seg_h[6:0])
            7'h3F: glyph_nib = 4'h0;
            7'h06: glyph_nib = 4'h1;
            7'h5B: glyph_nib = 4'h2;
            7'h4F: glyph_nib = 4'h3;
            7'h66: glyph_nib = 4'h4;
            7'h6D: glyph_nib = 4'h5;
            7'h7D: glyph_nib = 4'h6;
            7'h07: glyph_nib = 4'h7;
            7'h7F: glyph_nib = 4'h8;
            7'h6F: glyph_nib = 4'h9;
            7'h77: glyph_nib = 4'hA;
            7'h7C: glyph_nib = 4'hB;
            7'h39: glyph_nib = 4'hC;
            7'h5E: glyph_nib = 4'hD;
            7'h79: glyph_nib = 4'hE;
            7'h71: glyph_nib = 4'hF;
            default: glyph_err = 1'b1;
        endcase
    end

    // A fresh one-hot sample starts the dwell at 1, so STABLE_CNT=1 captures immediately.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell;
        capture  = 1'b0;
        if (!one_hot) begin
            state_nx = S_IDLE;
            dwell_nx = '0;
        end else if (!(state == S_HELD && same)) begin
            dwell_nx = (state == S_DWELL && same) ? dwell + 8'd1 : 8'd1;
            if (dwell_nx >= STABLE_TGT) begin
                capture  = 1'b1;
                state_nx = S_HELD;
            end else begin
                state_nx = S_DWELL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            dwell <= '0;
        end else begin
            state <= state_nx;
            dwell <= dwell_nx;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
        assign wr[i]        = capture && (idx == 2'(i));
        assign frame_nib[i] = wr[i] ? glyph_nib : slot_nib[i];
        assign frame_dp[i]  = wr[i] ? seg_h[7]  : slot_dp[i];
        assign frame_err[i] = wr[i] ? glyph_err : slot_err[i];

        seg_scan_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr[i]),
            .clr    (clr),
            .nib_in (glyph_nib),
            .dp_in  (seg_h[7]),
            .err_in (glyph_err),
            .nib    (slot_nib[i]),
            .dp     (slot_dp[i]),
            .err    (slot_err[i]),
            .seen   (seen[i])
        );
    end

    assign complete = capture && ((seen | wr) == 4'hF);
    assign expire   = !capture && (idle_cnt == TIMEOUT_TGT) && (seen != '0);
    assign clr      = complete || expire;

    // Saturates at TIMEOUT while nothing is pending; restarts after a discard or capture.
    always_ff @(posedge clk) begin
        if (rst || capture || expire)
            idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_TGT)
            idle_cnt <= idle_cnt + 16'd1;
    end

`ifdef SEG_SCAN_CHANGE_ONLY_EN
    logic primed;
    always_ff @(posedge clk) begin
        if (rst)
            primed <= 1'b0;
        else if (complete)
            primed <= 1'b1;
    end
    assign pulse_ok = !primed || ({frame_nib, frame_dp, frame_err} != {value, dp, err});
`else
    assign pulse_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            dp          <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= complete && pulse_ok;
            timeout     <= expire;
            if (complete) begin
                value <= frame_nib;
                dp    <= frame_dp;
                err   <= frame_err;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues expected frames, a monitor pops on frame_valid.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sel = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [15:0] value;
    logic [3:0]  dp, err;
    logic        frame_valid, timeout;

    seg_scan_decoder #(
        .STABLE_CNT     (4),
        .TIMEOUT        (64),
        .SEL_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .seg         (seg),
        .value       (value),
        .dp          (dp),
        .err         (err),
        .frame_valid (frame_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int to_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        frame_t f;
        f.value = v;
        f.dp    = d;
        f.err   = e;
        exp_q.push_back(f);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    // Holds one digit (active-high segment pattern) on the bus for n clock edges.
    task automatic drive(input int d, input logic [7:0] seg_hi, input int n);
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        sel = ~(one << d);
        seg = ~seg_hi;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sel = 4'hF;
        seg = 8'hFF;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dpm, input int n);
        for (int i = 0; i < 4; i++)
            drive(i, {dpm[i], glyph(v[4*i +: 4])}, n);
    endtask

    always @(negedge clk) begin
        frame_t e;
        if (timeout === 1'b1) to_cnt++;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got value=%h dp=%b err=%b, required no pulse", value, dp, err);
            end else begin
                e = exp_q.pop_front();
                check("frame_value", 32'(value), 32'(e.value));
                check("frame_dp",    32'(dp),    32'(e.dp));
                check("frame_err",   32'(err),   32'(e.err));
            end
        end
    end

    initial begin
        int exp_fv;
        repeat (3) @(negedge clk);
        check("rst_value",   32'(value), 32'h0);
        check("rst_dp",      32'(dp), 32'h0);
        check("rst_err",     32'(err), 32'h0);
        check("rst_fvalid",  32'(frame_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;

        // 1: basic scan
        expect_frame(16'h4321, 4'h0, 4'h0);
        scan(16'h4321, 4'h0, 8);
        idle(6);
        check("t1_pulses", 32'(fv_cnt), 32'd1);

        // 2: digit 0 too short, then completed later
        drive(0, {1'b0, glyph(4'h5)}, 3);
        drive(1, {1'b0, glyph(4'h6)}, 8);
        drive(2, {1'b0, glyph(4'h7)}, 8);
        drive(3, {1'b0, glyph(4'h8)}, 8);
        idle(4);
        check("t2_no_pulse", 32'(fv_cnt), 32'd1);
        expect_frame(16'h8765, 4'h0, 4'h0);
        drive(0, {1'b0, glyph(4'h5)}, 4);
        idle(6);
        check("t2_pulses", 32'(fv_cnt), 32'd2);

        // 3: blank glyph on digit 2
        expect_frame(16'h0000, 4'h0, 4'b0100);
        drive(0, 8'h3F, 8);
        drive(1, 8'h3F, 8);
        drive(2, 8'h00, 8);
        drive(3, 8'h3F, 8);
        idle(6);
        check("t3_pulses", 32'(fv_cnt), 32'd3);

        // 4: partial frame times out
        drive(0, {1'b0, glyph(4'h9)}, 8);
        drive(1, {1'b0, glyph(4'h8)}, 8);
        idle(72);
        check("t4_timeouts", 32'(to_cnt), 32'd1);
        check("t4_value_kept", 32'(value), 32'h0000);
        check("t4_err_kept", 32'(err), 32'b0100);
        check("t4_no_pulse", 32'(fv_cnt), 32'd3);
        expect_frame(16'h6789, 4'h0, 4'h0);
        scan(16'h6789, 4'h0, 8);
        idle(6);
        check("t4_pulses", 32'(fv_cnt), 32'd4);

        // 5: reset mid-frame
        drive(0, {1'b0, glyph(4'h9)}, 8);
        drive(1, {1'b0, glyph(4'h8)}, 8);
        drive(2, {1'b0, glyph(4'h7)}, 8);
        @(negedge clk);
        rst = 1'b1;
        sel = 4'hF;
        seg = 8'hFF;
        repeat (2) @(negedge clk);
        check("t5_rst_value", 32'(value), 32'h0);
        check("t5_rst_err",   32'(err), 32'h0);
        check("t5_rst_fvalid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        expect_frame(16'h6789, 4'h0, 4'h0);
        scan(16'h6789, 4'h0, 8);
        idle(6);
        check("t5_pulses", 32'(fv_cnt), 32'd5);

        // 6: repeated identical frame with dp on digit 3
        expect_frame(16'hABCD, 4'b1000, 4'h0);
        scan(16'hABCD, 4'b1000, 8);
        idle(6);
`ifdef SEG_SCAN_CHANGE_ONLY_EN
        exp_fv = 6;
`else
        expect_frame(16'hABCD, 4'b1000, 4'h0);
        exp_fv = 7;
`endif
        scan(16'hABCD, 4'b1000, 8);
        idle(6);
        check("t6_dp", 32'(dp), 32'b1000);
        check("t6_pulses", 32'(fv_cnt), 32'(exp_fv));
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_timeouts", 32'(to_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
